// File: rtl/sink_serializer.sv
// rtl/sink_serializer.sv - packet FIFO plus MSB-first byte serializer; optional hwm port via SINK_SER_HIGH_WATER_EN
module sink_serializer #(
  parameter int PKT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 arstn,
  input  logic                 snk_valid,
  output logic                 snk_ready,
  input  logic [PKT_WIDTH-1:0] snk,
  input  logic                 tx_ready,
  output logic                 tx_valid,
  output logic [7:0]           tx,
  output logic                 busy
`ifdef SINK_SER_HIGH_WATER_EN
  ,
  input  logic                          hwm_clr,
  output logic [$clog2(FIFO_DEPTH):0]   hwm
`endif
);

  localparam int BYTE_WIDTH = 8;
  localparam int NUM_BYTES  = (PKT_WIDTH + BYTE_WIDTH - 1) / BYTE_WIDTH;
  localparam int SR_W       = NUM_BYTES * BYTE_WIDTH;
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int CW         = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  localparam logic [AW:0]   FULL_CNT  = FIFO_DEPTH[AW:0];
  localparam logic [CW-1:0] LAST_BYTE = CW'(NUM_BYTES - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Packet storage; no reset needed since count gates every read.
  logic [PKT_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  state_t          state_q, state_d;
  logic [SR_W-1:0] sr_q, sr_d;
  logic [CW-1:0]   byte_cnt_q, byte_cnt_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_q, tx_d;

  logic            push;
  logic            pop;
  logic [SR_W-1:0] head;

  // Ready depends only on the registered count, never on tx_ready.
  assign snk_ready = (count_q != FULL_CNT);
  assign push      = snk_valid && snk_ready;
  assign head      = SR_W'(mem[rd_ptr_q]);

  assign tx_valid  = tx_valid_q;
  assign tx        = tx_q;
  assign busy      = (count_q != '0) || (state_q == SEND);

  // Serializer next state: load on idle, shift per accepted byte, reload with no bubble.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    byte_cnt_d = byte_cnt_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop        = 1'b1;
          sr_d       = head;
          byte_cnt_d = LAST_BYTE;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (byte_cnt_q != '0) begin
            sr_d       = sr_q << BYTE_WIDTH;
            byte_cnt_d = byte_cnt_q - CW'(1);
          end else if (count_q != '0) begin
            pop        = 1'b1;
            sr_d       = head;
            byte_cnt_d = LAST_BYTE;
          end else begin
            sr_d    = sr_q << BYTE_WIDTH;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    tx_valid_d = (state_d == SEND);
    tx_d       = sr_d[SR_W-1 -: BYTE_WIDTH];
  end

  // FIFO pointer and occupancy update; push and pop together leave count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Packet write port.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= snk;
  end

  // State register for FIFO control and serializer; reset drops all buffered data.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      sr_q       <= '0;
      byte_cnt_q <= '0;
      tx_valid_q <= 1'b0;
      tx_q       <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      sr_q       <= sr_d;
      byte_cnt_q <= byte_cnt_d;
      tx_valid_q <= tx_valid_d;
      tx_q       <= tx_d;
    end
  end

`ifdef SINK_SER_HIGH_WATER_EN
  logic [AW:0] hwm_q, hwm_d;

  assign hwm = hwm_q;

  // High-water mark: clear loads the present count, otherwise keep the maximum seen.
  always_comb begin
    hwm_d = hwm_q;
    if (hwm_clr)              hwm_d = count_q;
    else if (count_q > hwm_q) hwm_d = count_q;
  end

  // High-water register.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) hwm_q <= '0;
    else        hwm_q <= hwm_d;
  end
`endif

endmodule

// File: tb/tb_sink_serializer.sv
// tb/tb_sink_serializer.sv - table and scoreboard bench for sink_serializer
module tb_sink_serializer;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic        snk_valid = 1'b0;
  logic        snk_ready;
  logic [15:0] snk = '0;
  logic        tx_ready = 1'b0;
  logic        tx_valid;
  logic [7:0]  tx;
  logic        busy;

  logic        s12_valid = 1'b0;
  logic        s12_ready;
  logic [11:0] s12 = '0;
  logic        tx12_ready = 1'b1;
  logic        tx12_valid;
  logic [7:0]  tx12;
  logic        busy12;

`ifdef SINK_SER_HIGH_WATER_EN
  logic        hwm_clr = 1'b0;
  logic [2:0]  hwm;
  logic [2:0]  hwm12;
`endif

  always #5 clk = ~clk;

  sink_serializer #(.PKT_WIDTH(16), .FIFO_DEPTH(4)) u_dut (
    .clk       (clk),
    .arstn     (arstn),
    .snk_valid (snk_valid),
    .snk_ready (snk_ready),
    .snk       (snk),
    .tx_ready  (tx_ready),
    .tx_valid  (tx_valid),
    .tx        (tx),
    .busy      (busy)
`ifdef SINK_SER_HIGH_WATER_EN
    ,
    .hwm_clr   (hwm_clr),
    .hwm       (hwm)
`endif
  );

  sink_serializer #(.PKT_WIDTH(12), .FIFO_DEPTH(4)) u_dut12 (
    .clk       (clk),
    .arstn     (arstn),
    .snk_valid (s12_valid),
    .snk_ready (s12_ready),
    .snk       (s12),
    .tx_ready  (tx12_ready),
    .tx_valid  (tx12_valid),
    .tx        (tx12),
    .busy      (busy12)
`ifdef SINK_SER_HIGH_WATER_EN
    ,
    .hwm_clr   (1'b0),
    .hwm       (hwm12)
`endif
  );

  typedef struct {
    logic [15:0] pkt;
    logic [7:0]  b0;
    logic [7:0]  b1;
    int          gap;
  } vec_t;

  vec_t       vecs [6];
  logic [7:0] exp_q [$];
  int         n_vec = 0;
  int         n_err = 0;
  int         n_bytes = 0;
  int         cyc = 0;
  int         last_xfer_cyc = -10;
  int         run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every accepted byte must match the head of the expected queue.
  always @(negedge clk) begin
    if (arstn && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_byte: got %h expected none", tx);
      end else begin
        check("tx_byte", {24'h0, tx}, {24'h0, exp_q.pop_front()});
      end
      n_bytes++;
      if (last_xfer_cyc == cyc - 1) run++;
      else run = 1;
      last_xfer_cyc = cyc;
    end
  end

  task automatic push(input logic [15:0] p, input logic [7:0] b0, input logic [7:0] b1);
    int t;
    t = 0;
    snk_valid = 1'b1;
    snk = p;
    exp_q.push_back(b0);
    exp_q.push_back(b1);
    @(negedge clk);
    while (!snk_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!snk_ready) check("push_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 snk_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check(name, {31'h0, (exp_q.size() == 0) && !busy}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int k;
    int b_start;
    logic [7:0] g0;
    logic [7:0] g1;

    vecs[0] = '{16'h0000, 8'h00, 8'h00, 0};
    vecs[1] = '{16'hFFFF, 8'hFF, 8'hFF, 0};
    vecs[2] = '{16'h0001, 8'h00, 8'h01, 3};
    vecs[3] = '{16'h8000, 8'h80, 8'h00, 1};
    vecs[4] = '{16'h1234, 8'h12, 8'h34, 5};
    vecs[5] = '{16'h5AA5, 8'h5A, 8'hA5, 2};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", {21'h0, snk_ready, tx_valid, tx, busy}, {21'h0, 1'b1, 1'b0, 8'h00, 1'b0});
    #1 arstn = 1'b1;
    @(posedge clk);
    #1;

    // latency and byte order of a single packet
    tx_ready = 1'b1;
    push(16'hA5C3, 8'hA5, 8'hC3);
    @(negedge clk);
    check("lat_cycle1", {30'h0, tx_valid, busy}, {30'h0, 1'b0, 1'b1});
    @(negedge clk);
    check("lat_cycle2", {23'h0, tx_valid, tx}, {23'h0, 1'b1, 8'hA5});
    @(negedge clk);
    check("lat_cycle3", {23'h0, tx_valid, tx}, {23'h0, 1'b1, 8'hC3});
    @(negedge clk);
    check("busy_fall", {30'h0, tx_valid, busy}, {30'h0, 1'b0, 1'b0});
    @(posedge clk);
    #1;

    // table of packets with a per-vector backpressure gap
    for (int i = 0; i < 6; i++) begin
      tx_ready = (vecs[i].gap == 0);
      push(vecs[i].pkt, vecs[i].b0, vecs[i].b1);
      repeat (vecs[i].gap) @(posedge clk);
      #1 tx_ready = 1'b1;
      wait_drain("vec_drain");
    end

    // fill under backpressure, hold, then release
    tx_ready = 1'b0;
    push(16'h1111, 8'h11, 8'h11);
    push(16'h2222, 8'h22, 8'h22);
    push(16'h3333, 8'h33, 8'h33);
    push(16'h4444, 8'h44, 8'h44);
    push(16'h5555, 8'h55, 8'h55);
    @(negedge clk);
    check("full_state", {30'h0, snk_ready, busy}, {30'h0, 1'b0, 1'b1});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_tx", {23'h0, tx_valid, tx}, {23'h0, 1'b1, 8'h11});
    end
    @(posedge clk);
    #1 tx_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("drain_valid_ready", {30'h0, tx_valid, snk_ready}, {30'h0, 1'b1, (i >= 2)});
    end
    @(negedge clk);
    check("drain_end", {31'h0, tx_valid}, 32'd0);
    check("drain_run", run, 32'd10);
    wait_drain("bp_drain");

    // three back-to-back packets
    tx_ready = 1'b1;
    push(16'h0102, 8'h01, 8'h02);
    push(16'h0304, 8'h03, 8'h04);
    push(16'h0506, 8'h05, 8'h06);
    wait_drain("b2b_drain");
    check("b2b_run", run, 32'd6);

    // reset after the first byte of a packet
    tx_ready = 1'b1;
    push(16'hBEEF, 8'hBE, 8'hEF);
    t = 0;
    @(negedge clk);
    while (!tx_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("rst_first_byte", {23'h0, tx_valid, tx}, {23'h0, 1'b1, 8'hBE});
    @(posedge clk);
    #1 arstn = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_reset", {21'h0, snk_ready, tx_valid, tx, busy}, {21'h0, 1'b1, 1'b0, 8'h00, 1'b0});
    #2 arstn = 1'b1;
    b_start = n_bytes;
    repeat (5) @(negedge clk);
    check("post_rst_quiet", {30'h0, tx_valid, busy}, {30'h0, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    push(16'h1234, 8'h12, 8'h34);
    wait_drain("post_rst_drain");
    check("post_rst_bytes", n_bytes - b_start, 32'd2);

    // 12-bit packet zero-extended at the MSB
    s12_valid = 1'b1;
    s12 = 12'hABC;
    @(negedge clk);
    check("w12_ready", {31'h0, s12_ready}, 32'd1);
    @(posedge clk);
    #1 s12_valid = 1'b0;
    k = 0;
    g0 = '0;
    g1 = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx12_valid && tx12_ready) begin
        if (k == 0) g0 = tx12;
        else if (k == 1) g1 = tx12;
        k++;
      end
    end
    check("w12_count", k, 32'd2);
    check("w12_byte0", {24'h0, g0}, 32'h0A);
    check("w12_byte1", {24'h0, g1}, 32'hBC);
    @(posedge clk);
    #1;

`ifdef SINK_SER_HIGH_WATER_EN
    hwm_clr = 1'b1;
    @(posedge clk);
    #1 hwm_clr = 1'b0;
    @(negedge clk);
    check("hwm_clr_start", {29'h0, hwm}, 32'd0);
    @(posedge clk);
    #1 tx_ready = 1'b0;
    push(16'h0A0B, 8'h0A, 8'h0B);
    push(16'h0C0D, 8'h0C, 8'h0D);
    push(16'h0E0F, 8'h0E, 8'h0F);
    push(16'h1011, 8'h10, 8'h11);
    repeat (2) @(negedge clk);
    check("hwm_fill", {29'h0, hwm}, 32'd3);
    @(posedge clk);
    #1 tx_ready = 1'b1;
    wait_drain("hwm_drain");
    check("hwm_after_drain", {29'h0, hwm}, 32'd3);
    hwm_clr = 1'b1;
    @(posedge clk);
    #1 hwm_clr = 1'b0;
    @(negedge clk);
    check("hwm_clr_empty", {29'h0, hwm}, 32'd0);
    @(posedge clk);
    #1;
`endif

    check("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
